// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-side request/response signals and the shared RAM port.
// The arbiter connects through the slave modport; caches and RAM see master.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Instruction cache side
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  // Data cache side
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  // RAM side
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              ramerr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for icache and dcache. A registered grant FSM picks
// one requester per access; lastD alternates priority when both contend.
module mem_arbiter (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StIAcc, StDAcc} state_e;

  localparam logic [1:0] RamAccess = 2'b10;
  localparam logic [1:0] RamError  = 2'b11;

  state_e state_q, state_d;
  logic   last_d_q, last_d_d;
  logic   ramerr_q, ramerr_d;
  logic   i_req, d_req;

  assign i_req = bus.iREN;
  assign d_req = bus.dREN | bus.dWEN;

  // Read data is a straight pass-through; only meaningful on the completion cycle.
  assign bus.iload  = bus.ramload;
  assign bus.dload  = bus.ramload;
  assign bus.ramerr = ramerr_q;

  // Grant state, last-grant flag and sticky error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      last_d_q <= 1'b0;
      ramerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      ramerr_q <= ramerr_d;
    end
  end

  // Grant decision, RAM strobes and per-requester wait signals.
  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    ramerr_d     = ramerr_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;

    case (state_q)
      StIdle: begin
        // On contention the requester that did not complete last goes next.
        if (i_req && d_req) begin
          state_d = last_d_q ? StIAcc : StDAcc;
        end else if (i_req) begin
          state_d = StIAcc;
        end else if (d_req) begin
          state_d = StDAcc;
        end
      end

      StIAcc: begin
        if (!i_req) begin
          // Withdrawn: drop strobes now, no completion, priority untouched.
          state_d = StIdle;
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          if (bus.ramstate == RamAccess) begin
            bus.iwait = 1'b0;
            last_d_d  = 1'b0;
            state_d   = StIdle;
          end else if (bus.ramstate == RamError) begin
            ramerr_d = 1'b1;
          end
        end
      end

      StDAcc: begin
        if (!d_req) begin
          state_d = StIdle;
        end else begin
          // Write wins when both dREN and dWEN are raised.
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = ~bus.dWEN;
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          if (bus.ramstate == RamAccess) begin
            bus.dwait = 1'b0;
            last_d_d  = 1'b1;
            state_d   = StIdle;
          end else if (bus.ramstate == RamError) begin
            ramerr_d = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// cache/RAM traffic, checked every cycle against a transaction-level model.
module tb_mem_arbiter;

  logic CLK;
  logic nRST;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk;
  int n_bad;

  // Reference model: who owns the RAM, who completed last, error seen, memory.
  int          owner;      // 0 none, 1 icache, 2 dcache
  logic        m_last_d;
  logic        m_err;
  logic        m_done_i;
  logic        m_done_d;
  int          n_done_i;
  int          n_done_d;
  int          done_seq[$];
  logic [31:0] mem [int unsigned];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic model_reset();
    owner    = 0;
    m_last_d = 1'b0;
    m_err    = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, advance model.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs);
    logic        ireq, dreq, e_ren, e_wen;
    logic [31:0] e_addr;
    @(negedge CLK);
    bus.iREN     = ir;
    bus.iaddr    = ia;
    bus.dREN     = dr;
    bus.dWEN     = dw;
    bus.daddr    = da;
    bus.dstore   = ds;
    bus.ramstate = rs;
    ireq     = ir;
    dreq     = dr | dw;
    e_ren    = 1'b0;
    e_wen    = 1'b0;
    e_addr   = '0;
    m_done_i = 1'b0;
    m_done_d = 1'b0;
    if (owner == 1 && ireq) begin
      e_ren    = 1'b1;
      e_addr   = ia;
      m_done_i = (rs == 2'b10);
    end else if (owner == 2 && dreq) begin
      e_wen    = dw;
      e_ren    = !dw;
      e_addr   = da;
      m_done_d = (rs == 2'b10);
    end
    bus.ramload = e_ren ? memrd(e_addr) : $urandom();
    #1;
    check_val("ramREN", {31'd0, bus.ramREN}, {31'd0, e_ren});
    check_val("ramWEN", {31'd0, bus.ramWEN}, {31'd0, e_wen});
    check_val("iwait", {31'd0, bus.iwait}, {31'd0, !m_done_i});
    check_val("dwait", {31'd0, bus.dwait}, {31'd0, !m_done_d});
    check_val("ramerr", {31'd0, bus.ramerr}, {31'd0, m_err});
    if (e_ren || e_wen) check_val("ramaddr", bus.ramaddr, e_addr);
    if (e_wen) check_val("ramstore", bus.ramstore, ds);
    if (m_done_i) check_val("iload", bus.iload, memrd(ia));
    if (m_done_d && !dw) check_val("dload", bus.dload, memrd(da));

    // Next-cycle ownership from the arbitration rules.
    case (owner)
      0: begin
        if (ireq && dreq) owner = m_last_d ? 1 : 2;
        else if (ireq)    owner = 1;
        else if (dreq)    owner = 2;
      end
      1: begin
        if (!ireq) owner = 0;
        else if (rs == 2'b10) begin
          owner = 0; m_last_d = 1'b0; n_done_i++; done_seq.push_back(1);
        end else if (rs == 2'b11) m_err = 1'b1;
      end
      default: begin
        if (!dreq) owner = 0;
        else if (rs == 2'b10) begin
          owner = 0; m_last_d = 1'b1; n_done_d++; done_seq.push_back(2);
          if (dw) mem[da] = ds;
        end else if (rs == 2'b11) m_err = 1'b1;
      end
    endcase
  endtask

  task automatic idle_cycle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
  endtask

  logic        i_act, d_act, d_wr, d_rd, i_on, d_on;
  logic [31:0] i_addr, d_addr, d_data;
  logic [1:0]  rs_r;
  int          w;

  initial begin
    n_chk = 0;
    n_bad = 0;
    n_done_i = 0;
    n_done_d = 0;
    model_reset();
    nRST         = 1'b0;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h0000_0040;
    bus.dREN     = 1'b1;
    bus.dWEN     = 1'b0;
    bus.daddr    = 32'h0000_0100;
    bus.dstore   = 32'h1111_2222;
    bus.ramload  = 32'h0;
    bus.ramstate = 2'b10;

    // Reset holds everything quiet even with both requests raised.
    #22;
    check_val("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    check_val("rst_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
    check_val("rst_iwait", {31'd0, bus.iwait}, 32'd1);
    check_val("rst_dwait", {31'd0, bus.dwait}, 32'd1);
    check_val("rst_ramaddr", bus.ramaddr, 32'd0);
    check_val("rst_ramstore", bus.ramstore, 32'd0);
    check_val("rst_ramerr", {31'd0, bus.ramerr}, 32'd0);
    @(negedge CLK);
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    nRST     = 1'b1;

    // Contention with zero-wait RAM: D first, then strict alternation.
    done_seq.delete();
    for (int k = 0; k < 10; k++) step(1'b1, 32'h8, 1'b1, 1'b0, 32'hC, 32'h0, 2'b10);
    check_val("cont_count", done_seq.size(), 32'd5);
    if (done_seq.size() > 0) check_val("cont_first_d", done_seq[0], 32'd2);
    for (int k = 1; k < done_seq.size(); k++)
      check_val("cont_alternate", {31'd0, done_seq[k] != done_seq[k-1]}, 32'd1);
    idle_cycle();

    // Single I read, zero-wait RAM.
    mem[32'h40] = 32'hDEAD_BEEF;
    step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
    step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
    check_val("iread_done", {31'd0, bus.iwait}, 32'd0);
    check_val("iread_data", bus.iload, 32'hDEAD_BEEF);
    idle_cycle();

    // D write with three BUSY cycles.
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h1234_5678, 2'b01);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h1234_5678, 2'b01);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h1234_5678, 2'b10);
    idle_cycle();
    check_val("dwrite_mem", memrd(32'h100), 32'h1234_5678);

    // dREN+dWEN: write wins; ERROR twice then ACCESS; ramerr sticky.
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 2'b11);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 2'b11);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 2'b11);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 2'b10);
    idle_cycle();
    idle_cycle();
    check_val("ramerr_sticky", {31'd0, bus.ramerr}, 32'd1);

    // Withdrawal: I granted, dropped while BUSY, pending D read follows.
    step(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 2'b01);
    step(1'b1, 32'h44, 1'b1, 1'b0, 32'h104, 32'h0, 2'b01);
    step(1'b0, 32'h44, 1'b1, 1'b0, 32'h104, 32'h0, 2'b01);
    step(1'b0, 32'h44, 1'b1, 1'b0, 32'h104, 32'h0, 2'b01);
    step(1'b0, 32'h44, 1'b1, 1'b0, 32'h104, 32'h0, 2'b10);
    idle_cycle();

    // Reset mid-access: strobes drop at once, access is dropped.
    step(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, 2'b01);
    step(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, 2'b01);
    nRST = 1'b0;
    #1;
    check_val("midrst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    check_val("midrst_iwait", {31'd0, bus.iwait}, 32'd1);
    check_val("midrst_ramerr", {31'd0, bus.ramerr}, 32'd0);
    model_reset();
    @(negedge CLK);
    bus.iREN = 1'b0;
    nRST     = 1'b1;

    // Randomized traffic from both caches against a random-latency RAM.
    i_act = 1'b0; d_act = 1'b0; d_wr = 1'b0; d_rd = 1'b0;
    i_addr = '0; d_addr = '0; d_data = '0;
    n_done_i = 0;
    n_done_d = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act  = 1'b1;
        i_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act  = 1'b1;
        d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        d_data = $urandom();
        d_wr   = $urandom_range(0, 1) == 1;
        d_rd   = d_wr ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      if (i_act && $urandom_range(0, 24) == 0) i_act = 1'b0;
      if (d_act && $urandom_range(0, 24) == 0) d_act = 1'b0;
      i_on = i_act;
      d_on = d_act;
      w = $urandom_range(0, 9);
      rs_r = (w < 2) ? 2'b00 : (w < 4) ? 2'b01 : (w < 9) ? 2'b10 : 2'b11;
      step(i_on, i_addr, d_on & d_rd, d_on & d_wr, d_addr, d_data, rs_r);
      if (m_done_i) i_act = 1'b0;
      if (m_done_d) d_act = 1'b0;
    end
    check_val("rand_i_served", {31'd0, n_done_i > 50}, 32'd1);
    check_val("rand_d_served", {31'd0, n_done_d > 50}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
